// File: rtl/fft_frame_capture_ctrl_pkg.sv
// Shared definitions for the FFT frame capture controller: state encoding and
// default sizing.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 14;
  localparam int DEF_FRAME_LEN = 1024;

  // Address width for a buffer of the given depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fft_frame_capture_ctrl_if.sv
// Host/FFT/UART-side signal bundle of the frame capture controller.
// The controller uses the master view; the surrounding system uses slave.
interface fft_frame_capture_ctrl_if
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              rx_ready;
  logic              abort;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              tx_done;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              busy;
  logic              frame_done;
  logic [1:0]        state;

  modport master (
    input  rx_ready, abort, data_valid, data_in, tx_done,
    output tx_start, tx_data, tx_ready, busy, frame_done, state
  );

  modport slave (
    output rx_ready, abort, data_valid, data_in, tx_done,
    input  tx_start, tx_data, tx_ready, busy, frame_done, state
  );
endinterface

// File: rtl/fft_frame_capture_ctrl_frame_buf_ram.sv
// Simple dual-port frame buffer: synchronous write, registered read with one
// cycle of latency. The array itself is never reset.
module frame_buf_ram #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fft_frame_capture_ctrl.sv
// Arms on a host request, captures one FFT frame into the buffer starting at the
// first fresh data_valid edge, then streams it to the UART one word per handshake.
module fft_frame_capture_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CONT_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft_frame_capture_ctrl_if.master bus
);
  localparam int                ADDR_W   = addr_w(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic              rx_q, dv_q;
  logic              rd_req_q, rd_req_d;
  logic              rd_vld_q, rd_vld_d;
  logic              out_q, out_d;
  logic              tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              frame_done_q, frame_done_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              rx_rise, dv_rise, word_out;

  assign rx_rise  = bus.rx_ready & ~rx_q;
  assign dv_rise  = bus.data_valid & ~dv_q;
  // A word counts as outstanding from the cycle its tx_start is driven.
  assign word_out = out_q | tx_start_q;

  frame_buf_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_LEN),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (bus.data_in),
    .re_i    (ram_re),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rx_q         <= 1'b0;
      dv_q         <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_vld_q     <= 1'b0;
      out_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rx_q         <= bus.rx_ready;
      dv_q         <= bus.data_valid;
      rd_req_q     <= rd_req_d;
      rd_vld_q     <= rd_vld_d;
      out_q        <= out_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_req_d     = 1'b0;
    rd_vld_d     = 1'b0;
    out_d        = out_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = wr_ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_rise) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (dv_rise) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wr_ptr_d  = ADDR_W'(1);
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.data_valid) begin
          ram_we = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            state_d  = ST_DRAIN;
            rd_ptr_d = '0;
            rd_req_d = 1'b1;
            out_d    = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Read issue -> data back next cycle -> registered tx_start/tx_data.
        ram_re   = rd_req_q;
        rd_vld_d = rd_req_q;
        if (rd_vld_q) begin
          tx_start_d = 1'b1;
          tx_data_d  = ram_rdata;
        end
        if (tx_start_q) out_d = 1'b1;
        if (bus.tx_done && word_out) begin
          out_d = 1'b0;
          if (rd_ptr_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = (CONT_MODE != 0) ? ST_ARM : ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_req_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides every event seen in the same cycle.
    if (bus.abort) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      rd_req_d     = 1'b0;
      rd_vld_d     = 1'b0;
      out_d        = 1'b0;
      tx_start_d   = 1'b0;
      frame_done_d = 1'b0;
      ram_we       = 1'b0;
      ram_re       = 1'b0;
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_ready   = (state_q == ST_DRAIN);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_fft_frame_capture_ctrl.sv
// Bench for fft_frame_capture_ctrl: one single-shot and one continuous-mode
// instance, driven by a vector table, hand sequences and random frames.
module tb_fft_frame_capture_ctrl;
  localparam int DW = 14;
  localparam int FL = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          rx [2];
  logic          ab [2];
  logic          dv [2];
  logic [DW-1:0] din [2];
  logic          done_man [2];
  logic          done_auto [2];
  bit            auto_en [2];
  int            dly [2];
  int            dcnt [2];
  int            fd [2];
  logic [DW-1:0] wq0 [$];
  logic [DW-1:0] wq1 [$];

  int n_cmp = 0;
  int n_bad = 0;

  fft_frame_capture_ctrl_if #(.DATA_W(DW)) b0 ();
  fft_frame_capture_ctrl_if #(.DATA_W(DW)) b1 ();

  assign b0.rx_ready = rx[0];  assign b1.rx_ready = rx[1];
  assign b0.abort = ab[0];     assign b1.abort = ab[1];
  assign b0.data_valid = dv[0]; assign b1.data_valid = dv[1];
  assign b0.data_in = din[0];  assign b1.data_in = din[1];
  assign b0.tx_done = done_man[0] | done_auto[0];
  assign b1.tx_done = done_man[1] | done_auto[1];

  fft_frame_capture_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .CONT_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master));
  fft_frame_capture_ctrl #(.DATA_W(DW), .FRAME_LEN(FL), .CONT_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.master));

  function automatic logic get_start(input int s);
    return (s != 0) ? b1.tx_start : b0.tx_start;
  endfunction
  function automatic logic [DW-1:0] get_data(input int s);
    return (s != 0) ? b1.tx_data : b0.tx_data;
  endfunction
  function automatic logic [1:0] get_state(input int s);
    return (s != 0) ? b1.state : b0.state;
  endfunction
  function automatic logic get_fdone(input int s);
    return (s != 0) ? b1.frame_done : b0.frame_done;
  endfunction
  function automatic logic get_txr(input int s);
    return (s != 0) ? b1.tx_ready : b0.tx_ready;
  endfunction
  function automatic logic get_busy(input int s);
    return (s != 0) ? b1.busy : b0.busy;
  endfunction

  // Output monitor and UART responder: tx_done follows each tx_start by dly cycles.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      done_auto[s] = 1'b0;
      if (get_fdone(s)) fd[s]++;
      if (get_start(s)) begin
        if (s == 0) wq0.push_back(b0.tx_data); else wq1.push_back(b1.tx_data);
      end
      if (!rst_n) dcnt[s] = 0;
      else if (dcnt[s] > 0) begin
        dcnt[s]--;
        if (dcnt[s] == 0) done_auto[s] = 1'b1;
      end
      if (auto_en[s] && get_start(s))
        dcnt[s] = (dly[s] == 0) ? int'($urandom_range(1, 6)) : dly[s];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clr_q(input int s);
    if (s == 0) wq0.delete(); else wq1.delete();
  endtask

  task automatic wait_start(input int s, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (get_start(s)) begin ok = 1'b1; break; end
    end
  endtask

  // Wait for frame_done, then compare the transmitted words with the model.
  task automatic finish_frame(input int s, input logic [DW-1:0] exp[$], input int fd0,
                              input string nm);
    bit seen = 1'b0;
    int n;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (get_fdone(s)) begin seen = 1'b1; break; end
    end
    chk({nm, "_frame_done"}, 32'(seen), 32'd1);
    chk({nm, "_state_after"}, 32'(get_state(s)), (s != 0) ? 32'd1 : 32'd0);
    chk({nm, "_tx_ready_after"}, 32'(get_txr(s)), 32'd0);
    repeat (3) @(negedge clk);
    chk({nm, "_frame_done_count"}, 32'(fd[s] - fd0), 32'd1);
    n = (s == 0) ? wq0.size() : wq1.size();
    chk({nm, "_word_count"}, 32'(n), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < n; i++)
      chk($sformatf("%s_word%0d", nm, i), 32'((s == 0) ? wq0[i] : wq1[i]), 32'(exp[i]));
  endtask

  task automatic send_det(input int s, input int base, input bit arm, input int gap_after,
                          input int gap_len, input string nm);
    logic [DW-1:0] exp[$];
    int fd0 = fd[s];
    clr_q(s);
    if (arm) begin
      rx[s] = 1'b0; @(negedge clk);
      rx[s] = 1'b1; @(negedge clk);
      rx[s] = 1'b0;
    end
    dv[s] = 1'b0; @(negedge clk);
    for (int i = 0; i < FL; i++) begin
      dv[s] = 1'b1; din[s] = DW'(base + i); exp.push_back(DW'(base + i));
      @(negedge clk);
      if (i == gap_after) begin
        dv[s] = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
    end
    dv[s] = 1'b0;
    finish_frame(s, exp, fd0, nm);
  endtask

  // Random frame: the model takes the first data_valid rising edge after arming,
  // then every sample presented with data_valid high, until a frame is filled.
  task automatic send_rand(input int s, input string nm);
    logic [DW-1:0] exp[$];
    bit started = 1'b0;
    logic prev;
    int fd0 = fd[s];
    int guard = 0;
    clr_q(s);
    rx[s] = 1'b0; dv[s] = 1'b0; @(negedge clk);
    rx[s] = 1'b1; dv[s] = 1'($urandom_range(0, 1)); din[s] = DW'($urandom);
    prev = dv[s];
    @(negedge clk);
    while (exp.size() < FL && guard < 300) begin
      rx[s] = 1'($urandom_range(0, 1));
      dv[s] = ($urandom_range(0, 9) < 7);
      din[s] = DW'($urandom);
      if (!started) begin
        if (dv[s] && !prev) begin started = 1'b1; exp.push_back(din[s]); end
      end else if (dv[s]) begin
        exp.push_back(din[s]);
      end
      prev = dv[s];
      guard++;
      @(negedge clk);
    end
    dv[s] = 1'b0; rx[s] = 1'b0;
    finish_frame(s, exp, fd0, nm);
  endtask

  typedef struct {
    logic          rx;
    logic          dv;
    logic [DW-1:0] din;
    logic [1:0]    exp_st;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [DW-1:0] e8[$];
    int fd0;

    tbl[0] = '{1'b0, 1'b1, DW'(0), 2'd0};
    tbl[1] = '{1'b1, 1'b1, DW'(0), 2'd1};
    tbl[2] = '{1'b1, 1'b1, DW'(0), 2'd1};
    tbl[3] = '{1'b1, 1'b1, DW'(0), 2'd1};
    tbl[4] = '{1'b0, 1'b0, DW'(0), 2'd1};
    for (int i = 5; i < 13; i++)
      tbl[i] = '{1'b0, 1'b1, DW'(32'h200 + i - 5), (i == 12) ? 2'd3 : 2'd2};

    for (int s = 0; s < 2; s++) begin
      rx[s] = 0; ab[s] = 0; dv[s] = 0; din[s] = '0; done_man[s] = 0;
      auto_en[s] = 0; dly[s] = 5; dcnt[s] = 0; fd[s] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset_state%0d", s), 32'(get_state(s)), 32'd0);
      chk($sformatf("reset_busy%0d", s), 32'(get_busy(s)), 32'd0);
      chk($sformatf("reset_tx_ready%0d", s), 32'(get_txr(s)), 32'd0);
      chk($sformatf("reset_tx_start%0d", s), 32'(get_start(s)), 32'd0);
      chk($sformatf("reset_tx_data%0d", s), 32'(get_data(s)), 32'd0);
      chk($sformatf("reset_frame_done%0d", s), 32'(get_fdone(s)), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: data_valid already high at arm time must not trigger capture.
    auto_en[0] = 1'b1; dly[0] = 5; clr_q(0); fd0 = fd[0];
    for (int i = 0; i < 13; i++) begin
      rx[0] = tbl[i].rx; dv[0] = tbl[i].dv; din[0] = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl_state_row%0d", i), 32'(get_state(0)), 32'(tbl[i].exp_st));
    end
    chk("tbl_busy_drain", 32'(get_busy(0)), 32'd1);
    chk("tbl_tx_ready_drain", 32'(get_txr(0)), 32'd1);
    dv[0] = 1'b0; done_man[0] = 1'b1;   // stray tx_done, nothing outstanding
    @(negedge clk);
    done_man[0] = 1'b0;
    chk("lat_no_start_e1", 32'(get_start(0)), 32'd0);
    @(negedge clk);
    chk("lat_start_e2", 32'(get_start(0)), 32'd1);
    chk("lat_data_e2", 32'(get_data(0)), 32'h200);
    e8.delete();
    for (int i = 0; i < FL; i++) e8.push_back(DW'(32'h200 + i));
    finish_frame(0, e8, fd0, "tbl_frame");

    // Plain frame, then frame with a 3-cycle gap after sample 4.
    send_det(0, 32'h100, 1'b1, -1, 0, "t1");
    send_det(0, 32'h140, 1'b1, 4, 3, "t3_gap");

    // Abort during capture, then abort coincident with the final tx_done.
    auto_en[0] = 1'b0;
    rx[0] = 1'b1; @(negedge clk); rx[0] = 1'b0; @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      dv[0] = 1'b1; din[0] = DW'(32'h3A0 + i); @(negedge clk);
    end
    dv[0] = 1'b0; ab[0] = 1'b1; @(negedge clk); ab[0] = 1'b0;
    chk("abort_cap_state", 32'(get_state(0)), 32'd0);
    chk("abort_cap_busy", 32'(get_busy(0)), 32'd0);
    fd0 = fd[0];
    rx[0] = 1'b1; @(negedge clk); rx[0] = 1'b0;
    for (int i = 0; i < FL; i++) begin
      dv[0] = 1'b1; din[0] = DW'(32'h300 + i); @(negedge clk);
    end
    dv[0] = 1'b0;
    for (int w = 0; w < FL; w++) begin
      wait_start(0, ok);
      chk($sformatf("abort_drain_start%0d", w), 32'(ok), 32'd1);
      chk($sformatf("abort_drain_data%0d", w), 32'(get_data(0)), 32'h300 + w);
      @(negedge clk); @(negedge clk);
      done_man[0] = 1'b1;
      if (w == FL - 1) ab[0] = 1'b1;
      @(negedge clk);
      done_man[0] = 1'b0; ab[0] = 1'b0;
    end
    chk("abort_drain_state", 32'(get_state(0)), 32'd0);
    chk("abort_drain_tx_ready", 32'(get_txr(0)), 32'd0);
    chk("abort_drain_frame_done", 32'(get_fdone(0)), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_drain_fd_count", 32'(fd[0] - fd0), 32'd0);
    auto_en[0] = 1'b1; dly[0] = 5;
    send_det(0, 32'h350, 1'b1, -1, 0, "t4_clean");

    // Continuous mode: back-to-back frames without a new request.
    auto_en[1] = 1'b1; dly[1] = 5;
    send_det(1, 32'h400, 1'b1, -1, 0, "t5_f1");
    send_det(1, 32'h480, 1'b0, 2, 1, "t5_f2");
    chk("t5_fd_total", 32'(fd[1]), 32'd2);
    ab[1] = 1'b1; @(negedge clk); ab[1] = 1'b0;
    chk("t5_abort_state", 32'(get_state(1)), 32'd0);

    // Randomized frames with random UART delays.
    dly[0] = 0;
    for (int r = 0; r < 5; r++) send_rand(0, $sformatf("rand%0d", r));
    dly[0] = 5;

    // Asynchronous reset in the middle of DRAIN.
    rx[0] = 1'b1; @(negedge clk); rx[0] = 1'b0;
    for (int i = 0; i < FL; i++) begin
      dv[0] = 1'b1; din[0] = DW'(32'h500 + i); @(negedge clk);
    end
    dv[0] = 1'b0;
    wait_start(0, ok);
    chk("rst_pre_start", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_state", 32'(get_state(0)), 32'd0);
    chk("rst_async_tx_ready", 32'(get_txr(0)), 32'd0);
    chk("rst_async_busy", 32'(get_busy(0)), 32'd0);
    chk("rst_async_tx_start", 32'(get_start(0)), 32'd0);
    chk("rst_async_tx_data", 32'(get_data(0)), 32'd0);
    chk("rst_async_frame_done", 32'(get_fdone(0)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dv[0] = 1'(i & 1); din[0] = DW'(i); @(negedge clk);
    end
    dv[0] = 1'b0;
    chk("rst_idle_hold", 32'(get_state(0)), 32'd0);
    send_det(0, 32'h600, 1'b1, -1, 0, "t6_rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
